// File: rtl/rob_ring_if.sv
// Dispatch, writeback, retire and flush signals of the reorder buffer.
// The master side drives dispatch, writeback and flush; the slave is the ROB.
interface rob_ring_if #(
    parameter int NUM_ENTRIES  = 16,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int WB_PORTS     = 3,
    parameter int PREG_BITS    = 6
);
    localparam int IDX_BITS = $clog2(NUM_ENTRIES);

    logic [DISP_WIDTH-1:0]              disp_valid;
    logic [DISP_WIDTH*5-1:0]            disp_areg;
    logic [DISP_WIDTH*PREG_BITS-1:0]    disp_preg;
    logic                               disp_ready;
    logic [DISP_WIDTH*IDX_BITS-1:0]     disp_idx;
    logic [WB_PORTS-1:0]                wb_valid;
    logic [WB_PORTS*IDX_BITS-1:0]       wb_idx;
    logic [WB_PORTS*32-1:0]             wb_val;
    logic [RETIRE_WIDTH-1:0]            ret_valid;
    logic [RETIRE_WIDTH*5-1:0]          ret_areg;
    logic [RETIRE_WIDTH*PREG_BITS-1:0]  ret_preg;
    logic [RETIRE_WIDTH*32-1:0]         ret_val;
    logic                               flush_valid;
    logic [IDX_BITS-1:0]                flush_idx;
    logic [IDX_BITS:0]                  rob_count;
    logic                               rob_empty;

    modport master (
        output disp_valid, disp_areg, disp_preg, wb_valid, wb_idx, wb_val, flush_valid, flush_idx,
        input  disp_ready, disp_idx, ret_valid, ret_areg, ret_preg, ret_val, rob_count, rob_empty
    );

    modport slave (
        input  disp_valid, disp_areg, disp_preg, wb_valid, wb_idx, wb_val, flush_valid, flush_idx,
        output disp_ready, disp_idx, ret_valid, ret_areg, ret_preg, ret_val, rob_count, rob_empty
    );
endinterface

// File: rtl/rob_ring.sv
// Circular in-order reorder buffer: multi-lane dispatch, multi-port writeback,
// prefix retire of completed entries, and squash of everything younger than a given index.
module rob_ring #(
    parameter int NUM_ENTRIES  = 16,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int WB_PORTS     = 3,
    parameter int PREG_BITS    = 6,
    localparam int IDX_BITS    = $clog2(NUM_ENTRIES)
) (
    input  logic      clk,
    input  logic      rst,
    rob_ring_if.slave rob
);
    localparam int CNT_BITS = IDX_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(NUM_ENTRIES);
    localparam logic [CNT_BITS-1:0] DISP_CNT = CNT_BITS'(DISP_WIDTH);

    logic [IDX_BITS-1:0]    head_r;
    logic [IDX_BITS-1:0]    tail_r;
    logic [CNT_BITS-1:0]    count_r;
    logic [NUM_ENTRIES-1:0] done_r;
    logic [NUM_ENTRIES-1:0] done_nxt_s;
    logic [4:0]             areg_r     [NUM_ENTRIES];
    logic [4:0]             areg_nxt_s [NUM_ENTRIES];
    logic [PREG_BITS-1:0]   preg_r     [NUM_ENTRIES];
    logic [PREG_BITS-1:0]   preg_nxt_s [NUM_ENTRIES];
    logic [31:0]            val_r      [NUM_ENTRIES];
    logic [31:0]            val_nxt_s  [NUM_ENTRIES];

    logic                    disp_ready_s;
    logic [CNT_BITS-1:0]     ndisp_s;
    logic [CNT_BITS-1:0]     nret_s;
    logic [RETIRE_WIDTH-1:0] ret_valid_s;
    logic                    ret_chain_s;
    logic [IDX_BITS-1:0]     flush_tail_s;
    logic [IDX_BITS-1:0]     span_low_s;
    logic [CNT_BITS-1:0]     span_s;
    logic [IDX_BITS-1:0]     widx_s;
    logic [IDX_BITS-1:0]     didx_s;
    logic                    dgo_s;

    // Space check on registered count only; same-cycle retires are not credited
    assign disp_ready_s = !rob.flush_valid && ((FULL_CNT - count_r) >= DISP_CNT);
    assign rob.disp_ready = disp_ready_s;
    assign rob.rob_count  = count_r;
    assign rob.rob_empty  = (count_r == {CNT_BITS{1'b0}});

    // Number of lanes accepted this cycle
    always_comb begin
        ndisp_s = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            ndisp_s = ndisp_s + CNT_BITS'(rob.disp_valid[k] & disp_ready_s);
        end
    end

    // Retire prefix: lane k needs every entry head..head+k occupied and done
    always_comb begin
        ret_chain_s = !rst;
        ret_valid_s = '0;
        nret_s      = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            ret_chain_s    = ret_chain_s && (count_r > CNT_BITS'(k))
                             && done_r[head_r + IDX_BITS'(k)];
            ret_valid_s[k] = ret_chain_s;
            nret_s         = nret_s + CNT_BITS'(ret_chain_s);
        end
    end

    // Retire payload and dispatch indices straight from registered state
    always_comb begin
        rob.ret_valid = ret_valid_s;
        rob.ret_areg  = '0;
        rob.ret_preg  = '0;
        rob.ret_val   = '0;
        rob.disp_idx  = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            rob.ret_areg[k*5 +: 5]                 = areg_r[head_r + IDX_BITS'(k)];
            rob.ret_preg[k*PREG_BITS +: PREG_BITS] = preg_r[head_r + IDX_BITS'(k)];
            rob.ret_val[k*32 +: 32]                = val_r[head_r + IDX_BITS'(k)];
        end
        for (int k = 0; k < DISP_WIDTH; k++) begin
            rob.disp_idx[k*IDX_BITS +: IDX_BITS] = tail_r + IDX_BITS'(k);
        end
    end

    // Flush rebuilds the occupancy from the surviving span; full ROB maps a zero span to NUM_ENTRIES
    always_comb begin
        flush_tail_s = rob.flush_idx + IDX_BITS'(1);
        span_low_s   = flush_tail_s - head_r;
        span_s       = ((span_low_s == {IDX_BITS{1'b0}}) && (count_r == FULL_CNT)) ?
                       FULL_CNT : {1'b0, span_low_s};
    end

    // Entry next-state: later ports override earlier ones, dispatch overrides writeback
    always_comb begin
        done_nxt_s = done_r;
        areg_nxt_s = areg_r;
        preg_nxt_s = preg_r;
        val_nxt_s  = val_r;
        widx_s     = '0;
        didx_s     = '0;
        dgo_s      = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            widx_s             = rob.wb_idx[p*IDX_BITS +: IDX_BITS];
            done_nxt_s[widx_s] = done_nxt_s[widx_s] | rob.wb_valid[p];
            val_nxt_s[widx_s]  = rob.wb_valid[p] ? rob.wb_val[p*32 +: 32] : val_nxt_s[widx_s];
        end
        for (int k = 0; k < DISP_WIDTH; k++) begin
            didx_s             = tail_r + IDX_BITS'(k);
            dgo_s              = rob.disp_valid[k] & disp_ready_s;
            done_nxt_s[didx_s] = done_nxt_s[didx_s] & ~dgo_s;
            areg_nxt_s[didx_s] = dgo_s ? rob.disp_areg[k*5 +: 5] : areg_nxt_s[didx_s];
            preg_nxt_s[didx_s] = dgo_s ? rob.disp_preg[k*PREG_BITS +: PREG_BITS]
                                       : preg_nxt_s[didx_s];
        end
    end

    // Pointers, occupancy and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            done_r  <= '0;
        end else if (rob.flush_valid) begin
            head_r  <= head_r + nret_s[IDX_BITS-1:0];
            tail_r  <= flush_tail_s;
            count_r <= span_s - nret_s;
            done_r  <= done_nxt_s;
        end else begin
            head_r  <= head_r + nret_s[IDX_BITS-1:0];
            tail_r  <= tail_r + ndisp_s[IDX_BITS-1:0];
            count_r <= count_r + ndisp_s - nret_s;
            done_r  <= done_nxt_s;
        end
    end

    // Entry payload; stale contents are harmless since done gates retirement
    always_ff @(posedge clk) begin
        areg_r <= areg_nxt_s;
        preg_r <= preg_nxt_s;
        val_r  <= val_nxt_s;
    end
endmodule
